// File: rtl/pipeline_sequencer_pkg.sv
// Shared constants for the pipeline sequencer: state codes and index sizing.
package pipeline_sequencer_pkg;

    localparam int STATE_W = 3;

    // Status codes are visible on the LED/readback port, so keep them stable.
    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 3'd0,
        ST_RECV  = 3'd1,
        ST_START = 3'd2,
        ST_WAIT  = 3'd3,
        ST_SEND  = 3'd4,
        ST_FIN   = 3'd5,
        ST_ERR   = 3'd6
    } seq_state_e;

    // Width of a stage index; a single stage still needs one bit.
    function automatic int idx_width(input int n);
        if (n > 1) begin
            return $clog2(n);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/pipeline_sequencer.sv
// Job sequencer: receive a frame, run each unmasked compute stage in order
// with a per-stage watchdog, then send the frame and park in FIN or ERR.
module pipeline_sequencer
    import pipeline_sequencer_pkg::*;
#(
    parameter  int NUM_STAGES = 6,
    parameter  int TIMEOUT_W  = 16,
    localparam int IDX_W      = idx_width(NUM_STAGES)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  run,
    input  logic                  set,
    input  logic [NUM_STAGES-1:0] skip_mask,
    input  logic [TIMEOUT_W-1:0]  timeout_cycles,
    output logic                  recv_run,
    input  logic                  recv_valid,
    output logic [NUM_STAGES-1:0] stage_start,
    input  logic [NUM_STAGES-1:0] stage_done,
    output logic                  send_run,
    input  logic                  send_valid,
    output logic                  finish,
    output logic                  error,
    output logic [IDX_W-1:0]      stage_idx,
    output logic [STATE_W-1:0]    state
);

    // Lowest unmasked stage index at or above 'from'; MSB of result = found.
    function automatic logic [IDX_W:0] find_unmasked(
        input logic [NUM_STAGES-1:0] mask,
        input int                    from
    );
        logic             found;
        logic [IDX_W-1:0] idx;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < NUM_STAGES; i++) begin
            if (!found && (i >= from) && !mask[i]) begin
                found = 1'b1;
                idx   = IDX_W'(i);
            end else begin
                found = found;
            end
        end
        return {found, idx};
    endfunction

    // One-hot decode of a stage index.
    function automatic logic [NUM_STAGES-1:0] stage_onehot(input logic [IDX_W-1:0] idx);
        logic [NUM_STAGES-1:0] vec;
        vec = '0;
        for (int i = 0; i < NUM_STAGES; i++) begin
            if (idx == IDX_W'(i)) begin
                vec[i] = 1'b1;
            end else begin
                vec[i] = 1'b0;
            end
        end
        return vec;
    endfunction

    seq_state_e            state_r;
    seq_state_e            state_nxt_s;
    logic [IDX_W-1:0]      stage_idx_r;
    logic [IDX_W-1:0]      idx_nxt_s;
    logic [TIMEOUT_W-1:0]  counter_r;
    logic [TIMEOUT_W-1:0]  cnt_nxt_s;
    logic [TIMEOUT_W-1:0]  cnt_inc_s;
    logic [NUM_STAGES-1:0] mask_r;
    logic [TIMEOUT_W-1:0]  tmo_r;
    logic                  load_cfg_s;
    logic                  done_active_s;
    logic                  timeout_hit_s;
    logic [IDX_W:0]        srch_first_s;
    logic [IDX_W:0]        srch_next_s;

    logic                  recv_run_r;
    logic                  send_run_r;
    logic                  finish_r;
    logic                  error_r;
    logic [NUM_STAGES-1:0] stage_start_r;

    // Condition decode: active-stage done, saturating watchdog, next-stage search.
    always_comb begin
        done_active_s = |(stage_done & stage_onehot(stage_idx_r));
        if (counter_r == {TIMEOUT_W{1'b1}}) begin
            cnt_inc_s = counter_r;
        end else begin
            cnt_inc_s = counter_r + {{(TIMEOUT_W-1){1'b0}}, 1'b1};
        end
        timeout_hit_s = (tmo_r != {TIMEOUT_W{1'b0}}) && (cnt_inc_s >= tmo_r);
        srch_first_s  = find_unmasked(mask_r, 0);
        srch_next_s   = find_unmasked(mask_r, int'(stage_idx_r) + 1);
    end

    // Next-state, next-index and next-counter logic; set overrides everything.
    always_comb begin
        state_nxt_s = state_r;
        idx_nxt_s   = stage_idx_r;
        cnt_nxt_s   = counter_r;
        load_cfg_s  = 1'b0;
        if (set) begin
            state_nxt_s = ST_IDLE;
            idx_nxt_s   = '0;
            cnt_nxt_s   = '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (run) begin
                        state_nxt_s = ST_RECV;
                        load_cfg_s  = 1'b1;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_RECV: begin
                    if (recv_valid && srch_first_s[IDX_W]) begin
                        state_nxt_s = ST_START;
                        idx_nxt_s   = srch_first_s[IDX_W-1:0];
                    end else if (recv_valid) begin
                        state_nxt_s = ST_SEND;
                    end else begin
                        state_nxt_s = ST_RECV;
                    end
                end
                ST_START: begin
                    state_nxt_s = ST_WAIT;
                    cnt_nxt_s   = '0;
                end
                ST_WAIT: begin
                    // A done in the timeout cycle still counts as success.
                    if (done_active_s && srch_next_s[IDX_W]) begin
                        state_nxt_s = ST_START;
                        idx_nxt_s   = srch_next_s[IDX_W-1:0];
                        cnt_nxt_s   = '0;
                    end else if (done_active_s) begin
                        state_nxt_s = ST_SEND;
                        cnt_nxt_s   = '0;
                    end else if (timeout_hit_s) begin
                        state_nxt_s = ST_ERR;
                        cnt_nxt_s   = cnt_inc_s;
                    end else begin
                        state_nxt_s = ST_WAIT;
                        cnt_nxt_s   = cnt_inc_s;
                    end
                end
                ST_SEND: begin
                    if (send_valid) begin
                        state_nxt_s = ST_FIN;
                    end else begin
                        state_nxt_s = ST_SEND;
                    end
                end
                ST_FIN: begin
                    state_nxt_s = ST_FIN;
                end
                ST_ERR: begin
                    state_nxt_s = ST_ERR;
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                    idx_nxt_s   = '0;
                    cnt_nxt_s   = '0;
                end
            endcase
        end
    end

    // State, index, watchdog counter and per-job configuration registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            stage_idx_r <= '0;
            counter_r   <= '0;
            mask_r      <= '0;
            tmo_r       <= '0;
        end else begin
            state_r     <= state_nxt_s;
            stage_idx_r <= idx_nxt_s;
            counter_r   <= cnt_nxt_s;
            if (load_cfg_s) begin
                mask_r <= skip_mask;
                tmo_r  <= timeout_cycles;
            end else begin
                mask_r <= mask_r;
                tmo_r  <= tmo_r;
            end
        end
    end

    // Registered control outputs, computed from the next state so they align with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            recv_run_r    <= 1'b0;
            send_run_r    <= 1'b0;
            finish_r      <= 1'b0;
            error_r       <= 1'b0;
            stage_start_r <= '0;
        end else begin
            recv_run_r <= (state_nxt_s == ST_RECV);
            send_run_r <= (state_nxt_s == ST_SEND);
            finish_r   <= (state_nxt_s == ST_FIN);
            error_r    <= (state_nxt_s == ST_ERR);
            if (state_nxt_s == ST_START) begin
                stage_start_r <= stage_onehot(idx_nxt_s);
            end else begin
                stage_start_r <= '0;
            end
        end
    end

    assign recv_run    = recv_run_r;
    assign send_run    = send_run_r;
    assign finish      = finish_r;
    assign error       = error_r;
    assign stage_start = stage_start_r;
    assign stage_idx   = stage_idx_r;
    assign state       = state_r;

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Directed self-checking bench for pipeline_sequencer (NUM_STAGES=6).
module tb_pipeline_sequencer;

    localparam int NS = 6;
    localparam int TW = 16;

    localparam int S_IDLE  = 0;
    localparam int S_RECV  = 1;
    localparam int S_START = 2;
    localparam int S_WAIT  = 3;
    localparam int S_SEND  = 4;
    localparam int S_FIN   = 5;
    localparam int S_ERR   = 6;

    logic          clk;
    logic          rst_n;
    logic          run;
    logic          set;
    logic [NS-1:0] skip_mask;
    logic [TW-1:0] timeout_cycles;
    logic          recv_run;
    logic          recv_valid;
    logic [NS-1:0] stage_start;
    logic [NS-1:0] stage_done;
    logic          send_run;
    logic          send_valid;
    logic          finish;
    logic          error;
    logic [2:0]    stage_idx;
    logic [2:0]    state;

    int n_checks = 0;
    int n_fail   = 0;

    pipeline_sequencer #(.NUM_STAGES(NS), .TIMEOUT_W(TW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .run            (run),
        .set            (set),
        .skip_mask      (skip_mask),
        .timeout_cycles (timeout_cycles),
        .recv_run       (recv_run),
        .recv_valid     (recv_valid),
        .stage_start    (stage_start),
        .stage_done     (stage_done),
        .send_run       (send_run),
        .send_valid     (send_valid),
        .finish         (finish),
        .error          (error),
        .stage_idx      (stage_idx),
        .state          (state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_state"}, state, S_IDLE);
        chk({tag, "_recv_run"}, recv_run, 0);
        chk({tag, "_send_run"}, send_run, 0);
        chk({tag, "_start"}, stage_start, 0);
        chk({tag, "_finish"}, finish, 0);
        chk({tag, "_error"}, error, 0);
        chk({tag, "_idx"}, stage_idx, 0);
    endtask

    // Accept a run and complete reception; leaves the DUT one cycle past recv_valid.
    task automatic start_job(input logic [NS-1:0] mask, input logic [TW-1:0] tmo);
        skip_mask      = mask;
        timeout_cycles = tmo;
        run            = 1'b1;
        step();
        run = 1'b0;
        chk("recv_state", state, S_RECV);
        chk("recv_run", recv_run, 1);
        recv_valid = 1'b1;
        step();
        recv_valid = 1'b0;
    endtask

    // Expect a start pulse on stage idx, then answer with done three cycles later.
    task automatic do_stage(input int idx);
        logic [NS-1:0] bit_v;
        bit_v = '0;
        bit_v[idx] = 1'b1;
        chk($sformatf("start_state%0d", idx), state, S_START);
        chk($sformatf("start_vec%0d", idx), stage_start, bit_v);
        chk($sformatf("start_idx%0d", idx), stage_idx, idx);
        step();
        chk($sformatf("pulse_len%0d", idx), stage_start, 0);
        step();
        step();
        stage_done = bit_v;
        step();
        stage_done = '0;
    endtask

    initial begin
        rst_n          = 1'b0;
        run            = 1'b0;
        set            = 1'b0;
        skip_mask      = '0;
        timeout_cycles = '0;
        recv_valid     = 1'b0;
        stage_done     = '0;
        send_valid     = 1'b0;

        #12;
        chk_all_zero("reset");
        step();
        rst_n = 1'b1;
        step();
        chk_all_zero("post_reset");

        // Full job, no mask, no timeout; run while busy must be ignored.
        start_job(6'b000000, 16'd0);
        for (int s = 0; s < NS; s++) begin
            if (s == 2) run = 1'b1;
            do_stage(s);
            run = 1'b0;
        end
        chk("full_send_state", state, S_SEND);
        chk("full_send_run", send_run, 1);
        send_valid = 1'b1;
        step();
        send_valid = 1'b0;
        chk("full_fin_state", state, S_FIN);
        chk("full_finish", finish, 1);
        chk("full_send_run_off", send_run, 0);
        run = 1'b1;
        step();
        run = 1'b0;
        chk("fin_hold", state, S_FIN);
        set = 1'b1;
        step();
        set = 1'b0;
        chk_all_zero("fin_clear");

        // Partial mask; the input mask changes mid-job and must be ignored.
        start_job(6'b010110, 16'd0);
        skip_mask = 6'b000000;
        do_stage(0);
        do_stage(3);
        do_stage(5);
        chk("mask_send", state, S_SEND);
        set = 1'b1;
        step();
        set = 1'b0;

        // All stages masked: straight from RECV to SEND.
        start_job(6'b111111, 16'd0);
        chk("allmask_send", state, S_SEND);
        chk("allmask_start", stage_start, 0);
        set = 1'b1;
        step();
        set = 1'b0;

        // Timeout on stage 2 after four WAIT cycles.
        start_job(6'b000000, 16'd4);
        timeout_cycles = 16'd0;
        do_stage(0);
        do_stage(1);
        chk("to_start2", stage_idx, 2);
        for (int k = 1; k <= 4; k++) begin
            step();
            chk($sformatf("to_wait%0d", k), state, S_WAIT);
        end
        step();
        chk("to_err_state", state, S_ERR);
        chk("to_error", error, 1);
        chk("to_idx", stage_idx, 2);
        run = 1'b1;
        step();
        step();
        run = 1'b0;
        chk("err_hold", error, 1);
        set = 1'b1;
        step();
        set = 1'b0;
        chk_all_zero("err_clear");

        // Done in the timeout cycle wins; spurious and START-cycle dones ignored.
        start_job(6'b000000, 16'd4);
        chk("race_start0", state, S_START);
        for (int k = 1; k <= 4; k++) step();
        chk("race_wait4", state, S_WAIT);
        stage_done = 6'b000001;
        step();
        stage_done = '0;
        chk("race_progress", state, S_START);
        chk("race_idx1", stage_idx, 1);
        step();
        stage_done = 6'b111101;
        step();
        chk("spur_wait_a", state, S_WAIT);
        step();
        chk("spur_wait_b", state, S_WAIT);
        chk("spur_idx", stage_idx, 1);
        stage_done = 6'b000010;
        step();
        chk("spur_then_done", state, S_START);
        chk("spur_idx2", stage_idx, 2);
        stage_done = 6'b000100;
        step();
        stage_done = '0;
        chk("start_done_ignored", state, S_WAIT);
        chk("start_done_idx", stage_idx, 2);
        set = 1'b1;
        step();
        set = 1'b0;

        // Asynchronous reset in the middle of WAIT.
        start_job(6'b000000, 16'd0);
        do_stage(0);
        chk("pre_rst_wait", state, S_START);
        step();
        rst_n = 1'b0;
        #1;
        chk_all_zero("async_rst");
        step();
        step();
        chk("rst_no_pulse", stage_start, 0);
        #2;
        rst_n = 1'b1;
        step();
        chk_all_zero("rst_release");

        // Set in the middle of SEND, then a clean restart.
        start_job(6'b111111, 16'd0);
        chk("set_send", state, S_SEND);
        set = 1'b1;
        step();
        set = 1'b0;
        chk_all_zero("set_mid_send");
        start_job(6'b000000, 16'd0);
        chk("restart_state", state, S_START);
        chk("restart_vec", stage_start, 6'b000001);
        chk("restart_idx", stage_idx, 0);
        set = 1'b1;
        step();
        set = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipeline_sequencer.md
PIPELINE_SEQUENCER -- requirements
Module: pipeline_sequencer

Interface
REQ-001 SHALL have parameter NUM_STAGES, default 6, number of compute stages between receive and send.
REQ-002 SHALL have parameter TIMEOUT_W, default 16, width of per-stage timeout counter.
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port run  input  1  start request from AXI-lite controller.
REQ-006 SHALL have port set  input  1  synchronous force-to-IDLE from AXI-lite controller.
REQ-007 SHALL have port skip_mask  input  NUM_STAGES  bit i=1 bypasses stage i.
REQ-008 SHALL have port timeout_cycles  input  TIMEOUT_W  max WAIT cycles per stage; 0 disables timeout.
REQ-009 SHALL have port recv_run  output  1  enables AXIS input collector.
REQ-010 SHALL have port recv_valid  input  1  frame fully received.
REQ-011 SHALL have port stage_start  output  NUM_STAGES  one-hot single-cycle start pulse.
REQ-012 SHALL have port stage_done  input  NUM_STAGES  per-stage completion.
REQ-013 SHALL have port send_run  output  1  enables AXIS output serializer.
REQ-014 SHALL have port send_valid  input  1  frame fully sent.
REQ-015 SHALL have port finish  output  1  high in FIN.
REQ-016 SHALL have port error  output  1  high in ERR.
REQ-017 SHALL have port stage_idx  output  clog2(NUM_STAGES) (min 1)  current/last stage index; on error, failing stage.
REQ-018 SHALL have port state  output  3  encoded state for LED/status readback.

Function
REQ-019 SHALL implement states IDLE, RECV, START, WAIT, SEND, FIN, ERR.
REQ-020 IDLE: run=1 -> RECV next cycle; run outside IDLE ignored.
REQ-021 RECV: recv_run=1; recv_valid=1 -> START at first unmasked stage, or SEND if all stages masked.
REQ-022 START: exactly one cycle; stage_start[stage_idx]=1; timeout counter cleared; -> WAIT.
REQ-023 WAIT: stage_done[stage_idx]=1 -> START at next unmasked index > stage_idx, else SEND.
REQ-024 WAIT: counter increments each cycle; counter reaching timeout_cycles (nonzero) without done -> ERR, stage_idx held.
REQ-025 done and timeout in same cycle: done wins.
REQ-026 stage_done bits of non-active stages, and any done sampled in START, SHALL be ignored.
REQ-027 SEND: send_run=1; send_valid=1 -> FIN.
REQ-028 FIN and ERR SHALL hold until set=1; run ignored.
REQ-029 set=1 SHALL force IDLE next cycle from any state, overriding all other transitions, clearing counter and stage_idx.
REQ-030 skip_mask and timeout_cycles SHALL be sampled on IDLE->RECV and held for the whole job.
REQ-031 Outputs recv_run, send_run, stage_start, finish, error SHALL be registered or decoded from state register only (no input-to-output combinational path).
REQ-032 Counter SHALL saturate, never wrap.

Reset
REQ-033 rst_n=0 SHALL immediately force state=IDLE, stage_idx=0, counter=0, masks/timeout regs=0.
REQ-034 During/after reset all outputs SHALL be 0 until a run is accepted; reset mid-job aborts without further start pulses.

Structure
REQ-035 State encodings and widths SHALL live in the shared consts header alongside existing state codes.
REQ-036 SHALL be one module; no sub-modules; next-unmasked-stage search SHALL be a function inside it.

Verification
REQ-037 NUM_STAGES=6, mask=0, done 3 cycles after each start -> starts on stages 0..5 in order, then SEND, FIN after send_valid.
REQ-038 mask=6'b010110 -> start pulses only on stages 0,3,5; mask=6'b111111 -> RECV straight to SEND.
REQ-039 timeout_cycles=4, stage 2 never done -> ERR after 4 WAIT cycles, stage_idx=2, error=1 until set.
REQ-040 done asserted on cycle counter hits timeout -> progresses, no ERR; spurious done on inactive stage -> no progress.
REQ-041 rst_n low mid-WAIT, and set high mid-SEND -> IDLE, all outputs 0, new run restarts cleanly.
